// File: rtl/fifo_pkg.sv
// Shared types and defaults for the flow-controlled FIFO.
package fifo_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } flow_state_e;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultDepth     = 8;

    // DEPTH must be a power of two >= 2 so pointers wrap for free; the top level
    // stops elaboration with $error otherwise.

endpackage

// File: rtl/fifo_flow_ctrl_if.sv
// Producer/consumer side bundle of the flow-controlled FIFO.
interface fifo_flow_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AW         = 3
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic [AW:0]           umbral_alto;
    logic [AW:0]           umbral_bajo;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  empty;
    logic                  full;
    logic [AW:0]           count;
    logic                  pause;
    logic                  continua;
    logic                  fifo_error;

    modport master (
        output push, pop, data_in, umbral_alto, umbral_bajo,
        input  data_out, valid_out, empty, full, count, pause, continua, fifo_error
    );

    modport slave (
        input  push, pop, data_in, umbral_alto, umbral_bajo,
        output data_out, valid_out, empty, full, count, pause, continua, fifo_error
    );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array, synchronous write, registered read.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-address write and read return the old word, which is what a full push+pop needs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with hysteresis pause/resume flow control toward the producer.
module fifo_flow_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned DEPTH      = DefaultDepth,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input logic              clk,
    input logic              reset,
    fifo_flow_ctrl_if.slave  bus_io
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("fifo_flow_ctrl: DEPTH must be a power of two >= 2");
    end

    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          valid_q;
    logic          err_q;
    flow_state_e   state_q;
    logic          empty, full, push_ok, pop_ok;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == DepthCnt);
        pop_ok  = bus_io.pop & ~empty;
        push_ok = bus_io.push & (~full | pop_ok);
        count_d = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            valid_q <= pop_ok;
            if ((bus_io.push & ~push_ok) | (bus_io.pop & ~pop_ok)) err_q <= 1'b1;
        end
    end

    // Thresholds compare against count_d so pause moves on the same edge count crosses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN:   if (count_d >= bus_io.umbral_alto) state_q <= ST_PAUSE;
                ST_PAUSE: if (count_d <= bus_io.umbral_bajo) state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk_i   (clk),
        .rst_i   (reset),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus_io.data_in),
        .re_i    (pop_ok),
        .raddr_i (rd_ptr_q),
        .rdata_o (bus_io.data_out)
    );

    assign bus_io.valid_out  = valid_q;
    assign bus_io.empty      = empty;
    assign bus_io.full       = full;
    assign bus_io.count      = count_q;
    assign bus_io.pause      = (state_q == ST_PAUSE);
    assign bus_io.continua   = (state_q != ST_PAUSE);
    assign bus_io.fifo_error = err_q;

endmodule
